// File: rtl/audio_pkg.sv
// Shared definitions for the audio FIFO player.
// Contents: FSM state encoding and the PWM midscale helper.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    // Half of full scale for a given sample width (2^(width-1)).
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/audio_fifo_player_pwm_dac.sv
// pwm_dac: single-bit PWM DAC with period-boundary duty load.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   run          counter runs while high; low clears counter and output
//   level        requested duty, sampled only at the period boundary
//   pwm_out      registered PWM output (high while counter < duty)
module pwm_dac
    import audio_pkg::*;
#(
    parameter int unsigned DAT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DAT_WIDTH-1:0] level,
    output logic                 pwm_out
);

    localparam logic [DAT_WIDTH-1:0] MID = DAT_WIDTH'(midscale(DAT_WIDTH));

    logic [DAT_WIDTH-1:0] cnt;
    logic [DAT_WIDTH-1:0] duty;
    logic [DAT_WIDTH-1:0] duty_now;

    // At the boundary the new level is compared in the same cycle it is
    // loaded, so every period is generated from a single duty value.
    always_comb begin
        duty_now = duty;
        if (cnt == '0) begin
            duty_now = level;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            duty    <= MID;
            pwm_out <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            pwm_out <= (cnt < duty_now);
            if (cnt == '0) begin
                duty <= level;
            end
        end
    end

endmodule

// File: rtl/audio_fifo_player.sv
// audio_fifo_player: pops one sample per sample period from a show-ahead
// FIFO and plays it as single-bit PWM audio; primes on start-up and
// detects/counts underruns.
// Build option: AUDIO_PLAYER_UNDERRUN_MUTE_EN -- when defined, an underrun
// replaces the held sample with midscale (silence) until the next pop.
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   enable         playback enable (level)
//   fifo_empty     FIFO empty flag
//   fifo_data      FIFO head word (valid while fifo_empty = 0)
//   fifo_rd        one-cycle pop strobe per accepted sample
//   pwm_out        PWM audio output
//   sample         last captured sample
//   sample_valid   one-cycle pulse when sample updates
//   underrun       one-cycle pulse when a tick finds the FIFO empty
//   underrun_cnt   saturating underrun count
//   active         high in PLAY
module audio_fifo_player
    import audio_pkg::*;
#(
    parameter int unsigned DAT_WIDTH  = 8,
    parameter int unsigned SAMPLE_DIV = 6250,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DAT_WIDTH-1:0] fifo_data,
    output logic                 fifo_rd,
    output logic                 pwm_out,
    output logic [DAT_WIDTH-1:0] sample,
    output logic                 sample_valid,
    output logic                 underrun,
    output logic [CNT_WIDTH-1:0] underrun_cnt,
    output logic                 active
);

    localparam int unsigned          DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DAT_WIDTH-1:0] MID      = DAT_WIDTH'(midscale(DAT_WIDTH));

    state_t               state;
    logic [DIV_W-1:0]     div;
    logic                 tick;
    logic                 pwm_run;
    logic [DAT_WIDTH-1:0] pwm_level;

    always_comb begin
        tick = (state == PLAY) && (div == DIV_LAST);
    end

    // Gating with enable lets the PWM clear on the same edge as the state.
    always_comb begin
        pwm_run   = enable && (state != IDLE);
        pwm_level = (state == PLAY) ? sample : MID;
    end

    // A tick is honoured even when enable drops in that cycle, so a pop
    // that is already decided always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            div          <= '0;
            fifo_rd      <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            active       <= 1'b0;
        end else begin
            fifo_rd      <= 1'b0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;

            if (tick) begin
                if (!fifo_empty) begin
                    fifo_rd      <= 1'b1;
                    sample       <= fifo_data;
                    sample_valid <= 1'b1;
                end else begin
                    underrun <= 1'b1;
                    if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + 1'b1;
                    end
`ifdef AUDIO_PLAYER_UNDERRUN_MUTE_EN
                    sample <= MID;
`else
                    sample <= sample;
`endif
                end
            end

            if (!enable) begin
                state  <= IDLE;
                div    <= '0;
                active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= PRIME;
                        div   <= '0;
                    end
                    PRIME: begin
                        div <= '0;
                        if (!fifo_empty) begin
                            state  <= PLAY;
                            active <= 1'b1;
                        end
                    end
                    PLAY: begin
                        div <= tick ? '0 : div + 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        div    <= '0;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

    pwm_dac #(
        .DAT_WIDTH(DAT_WIDTH)
    ) u_pwm_dac (
        .clk    (clk),
        .reset  (reset),
        .run    (pwm_run),
        .level  (pwm_level),
        .pwm_out(pwm_out)
    );

endmodule

// File: tb/tb_audio_fifo_player.sv
// Directed bench for audio_fifo_player: main instance at 8-bit / 512-clock
// sample period, plus a small 4-bit / 16-clock / 3-bit-counter instance for
// underrun-count saturation.
module tb_audio_fifo_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       pwm_out;
    logic [7:0] sample;
    logic       sample_valid;
    logic       underrun;
    logic [15:0] underrun_cnt;
    logic       active;

    logic       reset2;
    logic       enable2;
    logic       fifo_empty2;
    logic [3:0] fifo_data2;
    logic       fifo_rd2;
    logic       pwm_out2;
    logic [3:0] sample2;
    logic       sample_valid2;
    logic       underrun2;
    logic [2:0] underrun_cnt2;
    logic       active2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    audio_fifo_player #(
        .DAT_WIDTH (8),
        .SAMPLE_DIV(512),
        .CNT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd     (fifo_rd),
        .pwm_out     (pwm_out),
        .sample      (sample),
        .sample_valid(sample_valid),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt),
        .active      (active)
    );

    audio_fifo_player #(
        .DAT_WIDTH (4),
        .SAMPLE_DIV(16),
        .CNT_WIDTH (3)
    ) dut_sat (
        .clk         (clk),
        .reset       (reset2),
        .enable      (enable2),
        .fifo_empty  (fifo_empty2),
        .fifo_data   (fifo_data2),
        .fifo_rd     (fifo_rd2),
        .pwm_out     (pwm_out2),
        .sample      (sample2),
        .sample_valid(sample_valid2),
        .underrun    (underrun2),
        .underrun_cnt(underrun_cnt2),
        .active      (active2)
    );

    // Show-ahead FIFO model for the main instance.
    logic [7:0] mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr % 16];
    always @(posedge clk) begin
        if (fifo_rd && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
    end

    // Single-word FIFO for the saturation instance.
    logic f2_popped;
    int   rd2_cnt = 0;
    assign fifo_empty2 = f2_popped;
    assign fifo_data2  = 4'h9;
    always @(posedge clk or posedge reset2) begin
        if (reset2) f2_popped <= 1'b0;
        else if (fifo_rd2) f2_popped <= 1'b1;
    end
    always @(posedge clk) begin
        if (fifo_rd2) rd2_cnt <= rd2_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 16] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Wait (bounded) for fifo_rd or underrun; n = negedges waited (-1 on
    // timeout), hi = pwm_out high count over the last 256 samples,
    // rds = fifo_rd pulses seen before the event.
    task automatic wait_for(input bit want_underrun, input int limit,
                            output int n, output int hi, output int rds);
        bit hist [256];
        bit done;
        done = 1'b0;
        n    = -1;
        hi   = 0;
        rds  = 0;
        for (int k = 0; k < 256; k++) hist[k] = 1'b0;
        for (int i = 1; i <= limit && !done; i++) begin
            @(negedge clk);
            hist[i % 256] = pwm_out;
            if (want_underrun ? underrun : fifo_rd) begin
                n    = i;
                done = 1'b1;
            end else begin
                rds = rds + int'(fifo_rd);
            end
        end
        if (done) begin
            for (int k = 0; k < 256; k++) hi = hi + int'(hist[k]);
        end
    endtask

    initial begin
        int n, hi, rds, pulses, cnt_hi, cnt_rd, cnt_ur;
        logic [7:0] exp_hold;
        logic [3:0] exp_hold2;
`ifdef AUDIO_PLAYER_UNDERRUN_MUTE_EN
        exp_hold  = 8'h80;
        exp_hold2 = 4'h8;
`else
        exp_hold  = 8'hF0;
        exp_hold2 = 4'h9;
`endif
        reset   = 1'b1;
        reset2  = 1'b1;
        enable  = 1'b1;
        enable2 = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
        check("rst_active", 32'(active), 32'd0);

        // Saturation: one pop, then underrun every 16 clocks; 3-bit count stops at 7.
        reset2 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 400 && pulses < 10; i++) begin
            @(negedge clk);
            if (underrun2) begin
                pulses++;
                check("sat_cnt", 32'(underrun_cnt2), (pulses < 7) ? 32'(pulses) : 32'd7);
            end
        end
        check("sat_pulses", 32'(pulses), 32'd10);
        check("sat_pops", 32'(rd2_cnt), 32'd1);
        check("sat_sample", 32'(sample2), 32'(exp_hold2));
        enable2 = 1'b0;

        // Release main reset with enable high: PRIME at midscale duty.
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("prime_active", 32'(active), 32'd0);
        cnt_hi = 0; cnt_rd = 0; cnt_ur = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt_hi += int'(pwm_out);
            cnt_rd += int'(fifo_rd);
            cnt_ur += int'(underrun);
        end
        check("prime_pwm_hi", 32'(cnt_hi), 32'd128);
        check("prime_no_rd", 32'(cnt_rd), 32'd0);
        check("prime_no_underrun", 32'(cnt_ur), 32'd0);

        // Three samples then drain.
        push(8'h10); push(8'h80); push(8'hF0);
        @(negedge clk);
        check("play_active", 32'(active), 32'd1);
        wait_for(1'b0, 600, n, hi, rds);
        check("pop1_latency", 32'(n), 32'd512);
        check("pop1_sample", 32'(sample), 32'h10);
        check("pop1_valid", 32'(sample_valid), 32'd1);
        @(negedge clk);
        check("pop1_rd_one_cycle", 32'(fifo_rd), 32'd0);
        check("pop1_valid_one_cycle", 32'(sample_valid), 32'd0);

        wait_for(1'b0, 600, n, hi, rds);
        check("pop2_interval", 32'(n), 32'd511);
        check("pop2_sample", 32'(sample), 32'h80);
        check("pwm_hi_0x10", 32'(hi), 32'd16);

        wait_for(1'b0, 600, n, hi, rds);
        check("pop3_interval", 32'(n), 32'd512);
        check("pop3_sample", 32'(sample), 32'hF0);
        check("pwm_hi_0x80", 32'(hi), 32'd128);

        wait_for(1'b1, 600, n, hi, rds);
        check("ur_interval", 32'(n), 32'd512);
        check("ur_no_rd", 32'(rds), 32'd0);
        check("ur_cnt", 32'(underrun_cnt), 32'd1);
        check("ur_sample", 32'(sample), 32'(exp_hold));
        check("pwm_hi_0xF0", 32'(hi), 32'd240);
        check("ur_active", 32'(active), 32'd1);

        // Refill one word; drop enable in the cycle fifo_rd is high.
        push(8'h40);
        wait_for(1'b0, 600, n, hi, rds);
        check("pop4_interval", 32'(n), 32'd512);
        check("pop4_sample", 32'(sample), 32'h40);
        check("pwm_hi_after_ur", 32'(hi), (exp_hold == 8'h80) ? 32'd128 : 32'd240);
        enable = 1'b0;
        @(negedge clk);
        check("dis_active", 32'(active), 32'd0);
        check("dis_pwm", 32'(pwm_out), 32'd0);
        check("dis_rd_cleared", 32'(fifo_rd), 32'd0);
        check("dis_word_popped", 32'(rd_ptr), 32'd4);
        check("dis_sample_kept", 32'(sample), 32'h40);
        check("dis_cnt_kept", 32'(underrun_cnt), 32'd1);
        cnt_hi = 0; cnt_rd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt_hi += int'(pwm_out);
            cnt_rd += int'(fifo_rd);
        end
        check("idle_pwm_quiet", 32'(cnt_hi), 32'd0);
        check("idle_no_rd", 32'(cnt_rd), 32'd0);

        // Restart, then reset while fifo_rd is high.
        push(8'h20);
        enable = 1'b1;
        for (int i = 0; i < 10 && !active; i++) @(negedge clk);
        check("restart_active", 32'(active), 32'd1);
        wait_for(1'b0, 600, n, hi, rds);
        check("restart_latency", 32'(n), 32'd512);
        check("restart_sample", 32'(sample), 32'h20);
        reset = 1'b1;
        #1;
        check("mid_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_cnt", 32'(underrun_cnt), 32'd0);
        check("mid_rst_sample", 32'(sample), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_pwm", 32'(pwm_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
